// File: rtl/gopf_eval_par.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gopf_eval_par: LANES-wide Horner evaluator of a Goppa polynomial over
// GF(2^GF_W), driving an external multiplier array.            Rev 1.0
// ----------------------------------------------------------------------------
module gopf_eval_par #(
  parameter int GF_W  = 16,
  parameter int LANES = 9,
  parameter int DEG   = 8,
  parameter int IDX_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LANES-1:0]          lane_en,
  input  logic [(DEG+1)*GF_W-1:0]   gopf,
  input  logic [LANES*GF_W-1:0]     gf2e_element,
  output logic                      busy,
  output logic                      eval_done,
  output logic [LANES*GF_W-1:0]     eval_r_dat,
  output logic [LANES-1:0]          root_flag,
  output logic                      zero_poly,
  output logic                      mul_req,
  output logic [LANES*GF_W-1:0]     mul_o_out,
  output logic [LANES*GF_W-1:0]     mul_t_out,
  input  logic                      mul_ack,
  input  logic [LANES*GF_W-1:0]     mul_r_dat
);

  localparam int PW = LANES * GF_W;
  localparam int CW = (DEG + 1) * GF_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MREQ  = 3'd2,
    S_MWAIT = 3'd3,
    S_ADD   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     coef_q, coef_d;
  logic [PW-1:0]     pts_q, pts_d;
  logic [LANES-1:0]  en_q, en_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PW-1:0]     res_q, res_d;
  logic [LANES-1:0]  root_q, root_d;
  logic              zero_q, zero_d;

  logic [PW-1:0]     lane_mask;
  logic [IDX_W-1:0]  top_idx;
  logic              any_nz;
  logic [GF_W-1:0]   c_top;
  logic [IDX_W-1:0]  idx_m1;
  logic [GF_W-1:0]   c_next;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_mask
      assign lane_mask[k*GF_W +: GF_W] = {GF_W{en_q[k]}};
    end
  endgenerate

  // Leading-coefficient search and coefficient selects for LOAD / ADD.
  always_comb begin
    top_idx = '0;
    any_nz  = 1'b0;
    c_top   = '0;
    c_next  = '0;
    idx_m1  = idx_q - IDX_W'(1);
    for (int i = 0; i <= DEG; i++) begin
      if (coef_q[i*GF_W +: GF_W] != '0) begin
        top_idx = IDX_W'(i);
        any_nz  = 1'b1;
      end
    end
    for (int i = 0; i <= DEG; i++) begin
      if (top_idx == IDX_W'(i)) c_top  = coef_q[i*GF_W +: GF_W];
      if (idx_m1  == IDX_W'(i)) c_next = coef_q[i*GF_W +: GF_W];
    end
  end

  always_comb begin
    state_d = state_q;
    coef_d  = coef_q;
    pts_d   = pts_q;
    en_d    = en_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    res_d   = res_q;
    root_d  = root_q;
    zero_d  = zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          coef_d  = gopf;
          pts_d   = gf2e_element;
          en_d    = lane_en;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        acc_d   = {LANES{c_top}} & lane_mask;
        idx_d   = top_idx;
        zero_d  = !any_nz;
        state_d = (top_idx == '0) ? S_DONE : S_MREQ;
      end
      S_MREQ: begin
        state_d = S_MWAIT;
      end
      S_MWAIT: begin
        // Products are captured here so the multiplier may drop them after ack.
        if (mul_ack) begin
          acc_d   = mul_r_dat & lane_mask;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        acc_d   = acc_q ^ ({LANES{c_next}} & lane_mask);
        idx_d   = idx_m1;
        state_d = (idx_m1 == '0) ? S_DONE : S_MREQ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Results are latched on entry to DONE so they are visible during the pulse.
    if (state_d == S_DONE) begin
      res_d = acc_d;
      for (int k = 0; k < LANES; k++) begin
        root_d[k] = en_q[k] && (acc_d[k*GF_W +: GF_W] == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      coef_q  <= '0;
      pts_q   <= '0;
      en_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      root_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      coef_q  <= coef_d;
      pts_q   <= pts_d;
      en_q    <= en_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      root_q  <= root_d;
      zero_q  <= zero_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign eval_done  = (state_q == S_DONE);
  assign mul_req    = (state_q == S_MREQ);
  assign mul_o_out  = pts_q & lane_mask;
  assign mul_t_out  = acc_q;
  assign eval_r_dat = res_q;
  assign root_flag  = root_q;
  assign zero_poly  = zero_q;

endmodule
`default_nettype wire
